rc_lockstep_checker: RTL

Parametrised lockstep equivalence checker for N_CH pairs of fixed-point model outputs, for example two rc_model instances driven by the same stimulus. It compares each pair every enabled cycle against an LSB tolerance and ignores a programmable settle window after reset or clear. A debounced, sticky fail flag is raised after a run of consecutive mismatching cycles. The block also keeps mismatch and cycle counters and captures the first mismatch, for use in formal and simulation equivalence benches.

---
 rtl/rc_lockstep_checker_if.sv | 45 ++++
 rtl/rc_lockstep_checker.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rc_lockstep_checker_if.sv
// ---------------------------------------------------------------------------
// rc_lockstep_checker_if
// Bus bundle for the lockstep equivalence checker.
//   en, clr        : compare enable and synchronous clear (driven by master)
//   a_in, b_in     : packed side-A / side-B samples, channel i in [i*WIDTH +: WIDTH]
//   checking       : checker is past its settle window
//   mismatch_vec   : per-channel mismatch from the last compared cycle
//   fail           : sticky debounced failure flag
//   first_*        : capture of the first mismatching cycle
//   mm_count       : cycles with any mismatch (saturating)
//   cycle_count    : compared cycles (saturating)
// master drives the stimulus side, slave is the checker.
// ---------------------------------------------------------------------------
interface rc_lockstep_checker_if #(
    parameter int N_CH  = 2,
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
);
    localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                    en;
    logic                    clr;
    logic [N_CH*WIDTH-1:0]   a_in;
    logic [N_CH*WIDTH-1:0]   b_in;
    logic                    checking;
    logic [N_CH-1:0]         mismatch_vec;
    logic                    fail;
    logic                    first_valid;
    logic [CHW-1:0]          first_ch;
    logic [CNT_W-1:0]        first_cycle;
    logic [CNT_W-1:0]        mm_count;
    logic [CNT_W-1:0]        cycle_count;

    modport master (
        output en, clr, a_in, b_in,
        input  checking, mismatch_vec, fail, first_valid,
               first_ch, first_cycle, mm_count, cycle_count
    );

    modport slave (
        input  en, clr, a_in, b_in,
        output checking, mismatch_vec, fail, first_valid,
               first_ch, first_cycle, mm_count, cycle_count
    );
endinterface

// File: rtl/rc_lockstep_checker.sv
// ---------------------------------------------------------------------------
// rc_lockstep_checker
// Lockstep equivalence checker for N_CH pairs of signed fixed-point samples.
// Each enabled cycle after a settle window, every channel pair is compared
// against an LSB tolerance; a run of FAIL_CONSEC mismatching cycles sets a
// sticky fail flag. Mismatch/cycle counters saturate, and the first
// mismatching cycle is captured.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset (same effect as bus.clr)
//   bus : rc_lockstep_checker_if.slave (en, clr, a_in, b_in in; status out)
// All outputs are registered: inputs sampled at edge k show up after edge k.
// ---------------------------------------------------------------------------

`ifndef SYNTHESIS
// Simulation-only monitor that flags the cycle on which fail rises.
module rc_lockstep_checker_sva (
    input logic clk,
    input logic rst,
    input logic fail
);
    logic fail_q_r;

    // Previous value of fail, used to detect its rising edge
    always_ff @(posedge clk) begin
        if (rst) begin
            fail_q_r <= 1'b0;
        end else begin
            fail_q_r <= fail;
        end
    end

    // Flag the lockstep divergence the moment fail goes high
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(fail && !fail_q_r))
                else $error("rc_lockstep_checker: lockstep fail raised");
        end
    end
endmodule
`endif

module rc_lockstep_checker #(
    parameter int N_CH        = 2,
    parameter int WIDTH       = 16,
    parameter int TOL         = 0,
    parameter int SETTLE      = 8,
    parameter int FAIL_CONSEC = 1,
    parameter int CNT_W       = 16,
    parameter int ASSERT_EN   = 1
) (
    input logic                  clk,
    input logic                  rst,
    rc_lockstep_checker_if.slave bus
);
    localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int SW  = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
    localparam int FW  = $clog2(FAIL_CONSEC + 1);

    localparam logic [WIDTH:0] TOL_L    = (WIDTH + 1)'(TOL);
    localparam logic [SW:0]    SETTLE_L = (SW + 1)'(SETTLE);
    localparam logic [FW-1:0]  FC_L     = FW'(FAIL_CONSEC);

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_CHECK  = 2'd1,
        ST_FAIL   = 2'd2
    } state_t;

    // |a - b| > TOL, evaluated at WIDTH+1 bits so extreme operands cannot wrap
    function automatic logic over_tol(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic signed [WIDTH:0] d;
        logic [WIDTH:0]        mag;
        d = $signed({a[WIDTH-1], a}) - $signed({b[WIDTH-1], b});
        if (d[WIDTH]) begin
            mag = $unsigned(-d);
        end else begin
            mag = $unsigned(d);
        end
        return (mag > TOL_L);
    endfunction

    // Saturating increment: counters stick at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_W'(1'b1);
        end
    endfunction

    state_t            state_r, state_s;
    logic [SW-1:0]     settle_cnt_r, settle_cnt_s;
    logic [SW:0]       settle_inc_s;
    logic [FW-1:0]     consec_r, consec_s, consec_inc_s;
    logic              checking_r, checking_s;
    logic [N_CH-1:0]   mismatch_vec_r, mismatch_vec_s;
    logic              fail_r, fail_s;
    logic              first_valid_r, first_valid_s;
    logic [CHW-1:0]    first_ch_r, first_ch_s;
    logic [CNT_W-1:0]  first_cycle_r, first_cycle_s;
    logic [CNT_W-1:0]  mm_count_r, mm_count_s;
    logic [CNT_W-1:0]  cycle_count_r, cycle_count_s;
    logic [N_CH-1:0]   raw_mm_s;
    logic [CHW-1:0]    low_ch_s;

    // Per-channel tolerance compare and lowest mismatching channel index
    always_comb begin
        raw_mm_s = '0;
        low_ch_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            raw_mm_s[i] = over_tol(bus.a_in[i*WIDTH +: WIDTH], bus.b_in[i*WIDTH +: WIDTH]);
        end
        // Walk downwards so the lowest index wins
        for (int i = N_CH - 1; i >= 0; i--) begin
            low_ch_s = raw_mm_s[i] ? CHW'(i) : low_ch_s;
        end
    end

    // Next-state, counter and output logic for the settle/check/fail FSM
    always_comb begin
        state_s        = state_r;
        settle_cnt_s   = settle_cnt_r;
        settle_inc_s   = {1'b0, settle_cnt_r} + (SW + 1)'(1'b1);
        consec_s       = consec_r;
        consec_inc_s   = consec_r + FW'(1'b1);
        mismatch_vec_s = '0;
        fail_s         = fail_r;
        first_valid_s  = first_valid_r;
        first_ch_s     = first_ch_r;
        first_cycle_s  = first_cycle_r;
        mm_count_s     = mm_count_r;
        cycle_count_s  = cycle_count_r;

        if (bus.en) begin
            case (state_r)
                ST_SETTLE: begin
                    settle_cnt_s = settle_inc_s[SW-1:0];
                    if (settle_inc_s >= SETTLE_L) begin
                        state_s = ST_CHECK;
                    end else begin
                        state_s = ST_SETTLE;
                    end
                end
                ST_CHECK, ST_FAIL: begin
                    mismatch_vec_s = raw_mm_s;
                    cycle_count_s  = sat_inc(cycle_count_r);
                    if (|raw_mm_s) begin
                        mm_count_s = sat_inc(mm_count_r);
                        if (!first_valid_r) begin
                            first_valid_s = 1'b1;
                            first_ch_s    = low_ch_s;
                            // Capture the count before this cycle's increment
                            first_cycle_s = cycle_count_r;
                        end else begin
                            first_valid_s = first_valid_r;
                        end
                    end else begin
                        mm_count_s = mm_count_r;
                    end
                    // Debounce only matters until fail latches
                    if (state_r == ST_CHECK) begin
                        if (|raw_mm_s) begin
                            consec_s = consec_inc_s;
                        end else begin
                            consec_s = '0;
                        end
                        if ((|raw_mm_s) && (consec_inc_s >= FC_L)) begin
                            state_s = ST_FAIL;
                            fail_s  = 1'b1;
                        end else begin
                            state_s = ST_CHECK;
                        end
                    end else begin
                        state_s = ST_FAIL;
                    end
                end
                default: begin
                    state_s = ST_SETTLE;
                end
            endcase
        end else begin
            mismatch_vec_s = '0;
        end

        checking_s = (state_s != ST_SETTLE);
    end

    // State and output registers; rst and clr both restart the settle window
    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            state_r        <= ST_SETTLE;
            settle_cnt_r   <= '0;
            consec_r       <= '0;
            checking_r     <= 1'b0;
            mismatch_vec_r <= '0;
            fail_r         <= 1'b0;
            first_valid_r  <= 1'b0;
            first_ch_r     <= '0;
            first_cycle_r  <= '0;
            mm_count_r     <= '0;
            cycle_count_r  <= '0;
        end else begin
            state_r        <= state_s;
            settle_cnt_r   <= settle_cnt_s;
            consec_r       <= consec_s;
            checking_r     <= checking_s;
            mismatch_vec_r <= mismatch_vec_s;
            fail_r         <= fail_s;
            first_valid_r  <= first_valid_s;
            first_ch_r     <= first_ch_s;
            first_cycle_r  <= first_cycle_s;
            mm_count_r     <= mm_count_s;
            cycle_count_r  <= cycle_count_s;
        end
    end

    assign bus.checking     = checking_r;
    assign bus.mismatch_vec = mismatch_vec_r;
    assign bus.fail         = fail_r;
    assign bus.first_valid  = first_valid_r;
    assign bus.first_ch     = first_ch_r;
    assign bus.first_cycle  = first_cycle_r;
    assign bus.mm_count     = mm_count_r;
    assign bus.cycle_count  = cycle_count_r;

    generate
        if (ASSERT_EN != 0) begin : g_sva
`ifndef SYNTHESIS
            rc_lockstep_checker_sva u_sva (
                .clk  (clk),
                .rst  (rst),
                .fail (fail_r)
            );
`endif
        end
    endgenerate
endmodule
